fb_pixel_feeder: RTL

- Replaces the test-pattern stage in the HDMI path: sits between the video timing generator (sync_vg) and the ADV7513 parallel pixel bus.
- Consumes sync_vg timing (x, y, vs, hs, de) and pops 24-bit RGB pixels from a first-word-fall-through frame FIFO filled by the camera/frame-buffer reader.
- Emits registered sync plus RGB with 1-cycle latency, matching pattern_vg timing so it is a drop-in swap.
- Detects FIFO underflow and overrun, and resynchronises on frame boundaries, pulsing frame_sync so the writer can restart the frame.

---
 rtl/fb_pixel_feeder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fb_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fb_pixel_feeder
// Function : Feeds frame-FIFO pixels onto the ADV7513 bus in lock-step with
//            sync_vg timing, with underflow/overrun detection and frame resync.
//            Optional stats counters: define FB_PIXEL_FEEDER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fb_pixel_feeder #(
  parameter int B                 = 8,
  parameter int X_BITS            = 12,
  parameter int Y_BITS            = 12,
  parameter logic [3*B-1:0] UF_COLOR = 24'h0000FF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              clr_flags,
  input  logic [X_BITS-1:0] x,
  input  logic [Y_BITS-1:0] y,
  input  logic              vn_in,
  input  logic              hn_in,
  input  logic              dn_in,
  input  logic [3*B-1:0]    fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              vn_out,
  output logic              hn_out,
  output logic              den_out,
  output logic [B-1:0]      r_out,
  output logic [B-1:0]      g_out,
  output logic [B-1:0]      b_out,
  output logic              frame_sync,
  output logic              underflow,
  output logic              overrun,
  output logic [1:0]        state_out
`ifdef FB_PIXEL_FEEDER_STATS_EN
  ,
  output logic [15:0]       underflow_cnt,
  output logic [15:0]       frame_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRAIN      = 2'd1,
    WAIT_FRAME = 2'd2,
    ACTIVE     = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_vs_rise;
  logic           w_frame_start;
  logic           w_deliver;
  logic           w_uf_evt;
  logic           w_ov_evt;
  logic           w_clean_evt;
  logic           w_starve;
  logic [3*B-1:0] w_rgb_nxt;

  // vn_out doubles as the one-cycle-delayed copy of vn_in for edge detection
  assign w_vs_rise     = vn_in & ~vn_out;
  assign w_frame_start = dn_in && (x == '0) && (y == '0);
  assign w_starve      = dn_in & fifo_empty;

  always_comb begin
    fifo_rd_en = 1'b0;
    case (r_state)
      DRAIN:      fifo_rd_en = ~fifo_empty;
      WAIT_FRAME: fifo_rd_en = w_frame_start & ~fifo_empty;
      ACTIVE:     fifo_rd_en = dn_in & ~fifo_empty;
      default:    fifo_rd_en = 1'b0;
    endcase
  end

  // Drain pops are discards; only pops in WAIT_FRAME/ACTIVE reach the bus
  assign w_deliver = fifo_rd_en & ((r_state == WAIT_FRAME) | (r_state == ACTIVE));

  assign w_uf_evt    = enable & (((r_state == WAIT_FRAME) & w_frame_start & fifo_empty) |
                                 ((r_state == ACTIVE) & w_starve));
  assign w_ov_evt    = enable & (r_state == ACTIVE) & ~w_starve & w_vs_rise & ~fifo_empty;
  assign w_clean_evt = enable & (r_state == ACTIVE) & ~w_starve & w_vs_rise & fifo_empty;

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:       w_state_nxt = DRAIN;
        DRAIN:      if (w_vs_rise) w_state_nxt = WAIT_FRAME;
        WAIT_FRAME: if (w_frame_start) w_state_nxt = fifo_empty ? DRAIN : ACTIVE;
        ACTIVE: begin
          if (w_starve)       w_state_nxt = DRAIN;
          else if (w_vs_rise) w_state_nxt = fifo_empty ? WAIT_FRAME : DRAIN;
        end
        default:    w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_rgb_nxt = '0;
    if (dn_in && (r_state != IDLE)) begin
      w_rgb_nxt = w_deliver ? fifo_rd_data : UF_COLOR;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      vn_out     <= 1'b0;
      hn_out     <= 1'b0;
      den_out    <= 1'b0;
      r_out      <= '0;
      g_out      <= '0;
      b_out      <= '0;
      frame_sync <= 1'b0;
      underflow  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      vn_out     <= vn_in;
      hn_out     <= hn_in;
      den_out    <= dn_in;
      {r_out, g_out, b_out} <= w_rgb_nxt;
      frame_sync <= w_vs_rise & (r_state != IDLE);
      // A new event in the same cycle as a clear leaves the flag set
      underflow  <= w_uf_evt | (underflow & ~clr_flags);
      overrun    <= w_ov_evt | (overrun & ~clr_flags);
    end
  end

  assign state_out = r_state;

`ifdef FB_PIXEL_FEEDER_STATS_EN
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      underflow_cnt <= 16'd0;
      frame_cnt     <= 16'd0;
    end else begin
      if (clr_flags) begin
        underflow_cnt <= {15'd0, w_uf_evt};
        frame_cnt     <= {15'd0, w_clean_evt};
      end else begin
        if (w_uf_evt && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
        if (w_clean_evt) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
